// File: rtl/lut_lookup_arbiter_pkg.sv
// lut_lookup_arbiter_pkg: shared FSM encoding and index-width helper for the lookup arbiter
// Contents: state_t (IDLE/LOOKUP/RESP), clog2() returning at least 1 bit
package lut_lookup_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Index width that never collapses to zero bits for tiny counts
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/lut_lookup_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter that owns its priority pointer
// Ports: clk, rst (sync, active-high), req[N] requests, advance (allow pointer update),
//        grant[N] one-hot grant, grant_idx index of the granted requester
module rr_arbiter
    import lut_lookup_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  advance,
    output logic [N-1:0]          grant,
    output logic [clog2(N)-1:0]   grant_idx
);
    localparam int W = clog2(N);

    logic [W-1:0] ptr;
    logic         found;

    // Search starts one past the last winner and wraps
    always_comb begin
        found     = 1'b0;
        grant_idx = ptr;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found     = 1'b1;
                grant_idx = W'((int'(ptr) + i) % N);
            end
        end
        grant = found ? (N'(1) << grant_idx) : '0;
    end

    // Reset pointer to N-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= W'(N - 1);
        else if (advance && found)
            ptr <= grant_idx;
    end

endmodule

// File: rtl/lut_lookup_arbiter.sv
// lut_lookup_arbiter: round-robin shared key/data lookup table with registered, back-pressured response
// Ports: clk, rst (sync, active-high); req_valid/req_key/req_ready per requester;
//        resp_valid/resp_ready/resp_id/resp_data/resp_hit response;
//        cfg_we/cfg_idx/cfg_key/cfg_data/cfg_valid table write port;
//        stat_hits/stat_misses only when LUT_LOOKUP_STATS_EN is defined
module lut_lookup_arbiter
    import lut_lookup_arbiter_pkg::*;
#(
    parameter int                  NREQ         = 4,
    parameter int                  KEY_NUM      = 4,
    parameter int                  KEY_LEN      = 4,
    parameter int                  DATA_LEN     = 8,
    parameter int                  HAS_DEFAULT  = 0,
    parameter logic [DATA_LEN-1:0] DEFAULT_DATA = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*KEY_LEN-1:0]     req_key,
    output logic [NREQ-1:0]             req_ready,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [clog2(NREQ)-1:0]      resp_id,
    output logic [DATA_LEN-1:0]         resp_data,
    output logic                        resp_hit,
    input  logic                        cfg_we,
    input  logic [clog2(KEY_NUM)-1:0]   cfg_idx,
    input  logic [KEY_LEN-1:0]          cfg_key,
    input  logic [DATA_LEN-1:0]         cfg_data,
    input  logic                        cfg_valid
`ifdef LUT_LOOKUP_STATS_EN
    ,
    output logic [31:0]                 stat_hits,
    output logic [31:0]                 stat_misses
`endif
);
    localparam int IW = clog2(NREQ);

    state_t               state, next;
    logic [KEY_LEN-1:0]   tkey  [KEY_NUM];
    logic [DATA_LEN-1:0]  tdata [KEY_NUM];
    logic [KEY_NUM-1:0]   tval;
    logic [KEY_LEN-1:0]   key_q;
    logic [IW-1:0]        id_q, grant_idx;
    logic [NREQ-1:0]      grant, arb_req;
    logic                 look_hit;
    logic [DATA_LEN-1:0]  look_or;

    // Config writes take precedence over granting in the same cycle
    assign arb_req    = (state == IDLE && !cfg_we && !rst) ? req_valid : '0;
    assign req_ready  = grant;
    assign resp_valid = (state == RESP);

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .advance   (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        next = state;
        next = (state == IDLE)   ? (|grant ? LOOKUP : IDLE) :
               (state == LOOKUP) ? RESP :
                                   (resp_ready ? IDLE : RESP);
    end

    // Duplicate keys OR their data together
    always_comb begin
        look_hit = 1'b0;
        look_or  = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (tval[i] && tkey[i] == key_q) begin
                look_hit = 1'b1;
                look_or  = look_or | tdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tval <= '0;
            for (int i = 0; i < KEY_NUM; i++) begin
                tkey[i]  <= '0;
                tdata[i] <= '0;
            end
        end else if (cfg_we && int'(cfg_idx) < KEY_NUM) begin
            tkey[cfg_idx]  <= cfg_key;
            tdata[cfg_idx] <= cfg_data;
            tval[cfg_idx]  <= cfg_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_q     <= '0;
            id_q      <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_hit  <= 1'b0;
        end else begin
            state <= next;
            if (|grant) begin
                key_q <= req_key[grant_idx*KEY_LEN +: KEY_LEN];
                id_q  <= grant_idx;
            end
            if (state == LOOKUP) begin
                resp_id   <= id_q;
                resp_data <= look_hit ? look_or : (HAS_DEFAULT != 0 ? DEFAULT_DATA : '0);
                resp_hit  <= look_hit;
            end
        end
    end

`ifdef LUT_LOOKUP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == LOOKUP) begin
            if (look_hit)
                stat_hits <= stat_hits + 32'd1;
            else
                stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lut_lookup_arbiter.sv
// tb_lut_lookup_arbiter: directed scoreboard bench for lut_lookup_arbiter (default and default-data instances)
module tb_lut_lookup_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_key;
    logic        resp_ready;
    logic        cfg_we, cfg_valid;
    logic [1:0]  cfg_idx;
    logic [3:0]  cfg_key;
    logic [7:0]  cfg_data;

    logic [3:0]  req_ready, d_req_ready;
    logic        resp_valid, d_resp_valid, resp_hit, d_resp_hit;
    logic [1:0]  resp_id, d_resp_id;
    logic [7:0]  resp_data, d_resp_data;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       hit;
        logic [7:0] def_data;
    } exp_t;
    exp_t sb[$];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lut_lookup_arbiter u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_hit(resp_hit), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid)
    );

    lut_lookup_arbiter #(.HAS_DEFAULT(1), .DEFAULT_DATA(8'hFF)) u_def (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(d_req_ready),
        .resp_valid(d_resp_valid), .resp_ready(resp_ready), .resp_id(d_resp_id), .resp_data(d_resp_data),
        .resp_hit(d_resp_hit), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [3:0] key, input logic [7:0] data, input logic v);
        cfg_we = 1'b1; cfg_idx = idx; cfg_key = key; cfg_data = data; cfg_valid = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pop_check();
        exp_t e;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_data", 32'(resp_data), 32'(e.data));
            chk("resp_hit", 32'(resp_hit), 32'(e.hit));
            chk("def_resp_data", 32'(d_resp_data), 32'(e.def_data));
        end
    endtask

    // Grant was just checked; walks LOOKUP and RESP with resp_ready=1
    task automatic finish_resp();
        tick();
        chk("lookup_no_valid", 32'(resp_valid), 32'd0);
        tick();
        pop_check();
        tick();
    endtask

    task automatic serve(input logic [3:0] mask, input logic [15:0] keys, input logic [1:0] id,
                         input logic [7:0] data, input logic hit, input logic [7:0] def_data);
        req_valid = mask; req_key = keys;
        #1;
        chk("grant", 32'(req_ready), 32'(4'b0001 << id));
        sb.push_back('{id, data, hit, def_data});
        finish_resp();
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b1111; req_key = '0; resp_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_data = '0; cfg_valid = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        chk("idle_no_req", 32'(req_ready), 32'd0);

        // Basic hit and miss
        cfg(2'd0, 4'd3, 8'hA5, 1'b1);
        serve(4'b0001, 16'h0003, 2'd0, 8'hA5, 1'b1, 8'hA5);
        serve(4'b0001, 16'h0007, 2'd0, 8'h00, 1'b0, 8'hFF);

        // Round robin with everyone requesting, then requester 1 dropped
        serve(4'b1111, 16'h3333, 2'd1, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1111, 16'h3333, 2'd2, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1111, 16'h3333, 2'd3, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1111, 16'h3333, 2'd0, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1111, 16'h3333, 2'd1, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1101, 16'h3333, 2'd2, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1101, 16'h3333, 2'd3, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1101, 16'h3333, 2'd0, 8'hA5, 1'b1, 8'hA5);
        serve(4'b1101, 16'h3333, 2'd2, 8'hA5, 1'b1, 8'hA5);

        // Backpressure: response held stable, no new grants
        resp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b1000);
        sb.push_back('{2'd3, 8'hA5, 1'b1, 8'hA5});
        tick();
        tick();
        pop_check();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_id", 32'(resp_id), 32'd3);
            chk("bp_data", 32'(resp_data), 32'hA5);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        serve(4'b1111, 16'h3333, 2'd0, 8'hA5, 1'b1, 8'hA5);
        req_valid = '0;

        // Duplicate keys OR together; invalidation during LOOKUP is not seen by that lookup
        cfg(2'd1, 4'd5, 8'h0F, 1'b1);
        cfg(2'd2, 4'd5, 8'hF0, 1'b1);
        serve(4'b0001, 16'h0005, 2'd0, 8'hFF, 1'b1, 8'hFF);
        req_valid = 4'b0001;
        #1;
        chk("inv_grant", 32'(req_ready), 32'd1);
        sb.push_back('{2'd0, 8'hFF, 1'b1, 8'hFF});
        tick();
        chk("inv_lookup_no_valid", 32'(resp_valid), 32'd0);
        cfg(2'd1, 4'd5, 8'h0F, 1'b0);
        pop_check();
        tick();
        serve(4'b0001, 16'h0005, 2'd0, 8'hF0, 1'b1, 8'hF0);

        // Config write in IDLE blocks the grant for one cycle; lookup sees the new entry
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_key = 4'd9; cfg_data = 8'h33; cfg_valid = 1'b1;
        req_valid = 4'b0001; req_key = 16'h0009;
        #1;
        chk("cfg_blocks_grant", 32'(req_ready), 32'd0);
        tick();
        cfg_we = 1'b0;
        serve(4'b0001, 16'h0009, 2'd0, 8'h33, 1'b1, 8'h33);

        // Reset in RESP drops the response and clears the table
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'd1);
        tick();
        tick();
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("post_rst_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_data", 32'(resp_data), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        serve(4'b0001, 16'h0009, 2'd0, 8'h00, 1'b0, 8'hFF);
        serve(4'b0001, 16'h0003, 2'd0, 8'h00, 1'b0, 8'hFF);
        req_valid = '0;

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
